hack_rom_loader: RTL

HACK_ROM_LOADER -- requirements
Module: hack_rom_loader

---
 rtl/hack_rom_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/hack_rom_loader.sv
// Byte-stream loader that writes big-endian 16-bit words into the instruction ROM and
// holds the CPU in reset until a frame has loaded. Optional checksum byte: HACK_LOADER_CHECKSUM_EN.
module hack_rom_loader #(
  parameter logic [7:0]  HEADER    = 8'hA5,
  parameter int unsigned MAX_WORDS = 32767
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_s_data,
  input  logic        i_s_valid,
  output logic        o_s_ready,
  output logic        o_rom_we,
  output logic [14:0] o_rom_addr,
  output logic [15:0] o_rom_data,
  output logic        o_cpu_reset,
  output logic        o_done,
  output logic        o_error,
  output logic [2:0]  o_dbg_state
);

  // Handshake: a byte transfers on a rising edge where i_s_valid and o_s_ready are both 1;
  // the source may present or withdraw a byte freely while o_s_ready is 0.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CKSUM   = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  hi_q, hi_d;
  logic        we_q, we_d;
  logic [14:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        rdy_q;

  logic        accept;
  logic        is_header;
  logic [15:0] len_full;
  logic        last_word;

  assign accept    = i_s_valid && o_s_ready;
  assign is_header = (i_s_data == HEADER);
  assign len_full  = {len_hi_q, i_s_data};
  assign last_word = ((cnt_q + 16'd1) == len_q);

`ifdef HACK_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] sum_next;
  assign sum_next = sum_q + i_s_data;
`endif

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      len_hi_q <= 8'd0;
      len_q    <= 16'd0;
      cnt_q    <= 16'd0;
      hi_q     <= 8'd0;
      we_q     <= 1'b0;
      addr_q   <= 15'd0;
      data_q   <= 16'd0;
      rdy_q    <= 1'b0;
`ifdef HACK_LOADER_CHECKSUM_EN
      sum_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdy_q    <= 1'b1;
`ifdef HACK_LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        IDLE, DONE, ERROR: if (is_header) state_d = LEN_HI;
        LEN_HI:            state_d = LEN_LO;
        LEN_LO: begin
          if (32'(len_full) > MAX_WORDS) state_d = ERROR;
`ifdef HACK_LOADER_CHECKSUM_EN
          else if (len_full == 16'd0)    state_d = CKSUM;
`else
          else if (len_full == 16'd0)    state_d = DONE;
`endif
          else                           state_d = DATA_HI;
        end
        DATA_HI: state_d = DATA_LO;
        DATA_LO: begin
`ifdef HACK_LOADER_CHECKSUM_EN
          state_d = last_word ? CKSUM : DATA_HI;
`else
          state_d = last_word ? DONE : DATA_HI;
`endif
        end
`ifdef HACK_LOADER_CHECKSUM_EN
        CKSUM: state_d = (sum_next == 8'h00) ? DONE : ERROR;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath next values; the write address is the word count before the increment
  always_comb begin
    len_hi_d = len_hi_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
`ifdef HACK_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    if (accept) begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (is_header) begin
            cnt_d = 16'd0;
`ifdef HACK_LOADER_CHECKSUM_EN
            sum_d = 8'd0;
`endif
          end
        end
        LEN_HI: len_hi_d = i_s_data;
        LEN_LO: len_d    = len_full;
        DATA_HI: hi_d    = i_s_data;
        DATA_LO: begin
          we_d   = 1'b1;
          addr_d = cnt_q[14:0];
          data_d = {hi_q, i_s_data};
          cnt_d  = cnt_q + 16'd1;
        end
        default: ;
      endcase
`ifdef HACK_LOADER_CHECKSUM_EN
      if (state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO}) sum_d = sum_next;
`endif
    end
  end

  // Outputs
  always_comb begin
    o_s_ready   = rdy_q && !we_q;
    o_rom_we    = we_q;
    o_rom_addr  = addr_q;
    o_rom_data  = data_q;
    o_cpu_reset = (state_q != DONE);
    o_done      = (state_q == DONE);
    o_error     = (state_q == ERROR);
    o_dbg_state = state_q;
  end

endmodule
